// File: rtl/thirty_two_bit_divider_if.sv
// rtl/thirty_two_bit_divider_if.sv - execute-stage to divider handshake bundle
//
// Purpose: groups the start/busy/done handshake, operands and results.
// Signals (divider view):
//   i_start       request, sampled only while the divider is idle
//   i_is_signed   1 = DIV/REM, 0 = DIVU/REMU, captured with i_start
//   i_operator_1  dividend, captured with i_start
//   i_operator_2  divisor, captured with i_start
//   o_busy        high from the accept edge until the result edge
//   o_done        one-cycle pulse, results valid from this cycle
//   o_quotient    registered quotient, holds until the next o_done
//   o_remainder   registered remainder, holds until the next o_done
// Modports: master = execute stage, slave = divider.
interface thirty_two_bit_divider_if #(
    parameter int WIDTH = 32
);
    logic             i_start;
    logic             i_is_signed;
    logic [WIDTH-1:0] i_operator_1;
    logic [WIDTH-1:0] i_operator_2;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_quotient;
    logic [WIDTH-1:0] o_remainder;

    modport master (
        output i_start, i_is_signed, i_operator_1, i_operator_2,
        input  o_busy, o_done, o_quotient, o_remainder
    );

    modport slave (
        input  i_start, i_is_signed, i_operator_1, i_operator_2,
        output o_busy, o_done, o_quotient, o_remainder
    );
endinterface

// File: rtl/thirty_two_bit_divider.sv
// rtl/thirty_two_bit_divider.sv - multi-cycle radix-2 restoring divider (DIV/DIVU/REM/REMU)
//
// Purpose: produces quotient and remainder of one 32-bit integer division,
// one quotient bit per clock, with a start/busy/done handshake.
// Ports:
//   i_clk   system clock, rising edge
//   i_rst   asynchronous active-high reset
//   bus     thirty_two_bit_divider_if.slave (operands, handshake, results)
// Parameters:
//   WIDTH   operand/result width (32)
//   ITER    iteration count, must equal WIDTH
// Optional feature macro: DIV_FAST_SPECIAL_EN
//   defined   : divide-by-zero and signed overflow skip CALC (done after edge k+1)
//   undefined : special cases run all iterations, results forced in FINISH
module thirty_two_bit_divider #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    thirty_two_bit_divider_if.slave      bus
);
    localparam int CW = $clog2(ITER);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_counter;
    logic [WIDTH-1:0] r_dividend;      // shifts out dividend bits, shifts in quotient bits
    logic [WIDTH-1:0] r_partial_rem;
    logic [WIDTH-1:0] r_abs_divisor;
    logic [WIDTH-1:0] r_orig_dividend; // remainder for divide-by-zero
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_div_zero;
    logic             r_overflow;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;

    logic             w_op1_neg;
    logic             w_op2_neg;
    logic [WIDTH-1:0] w_abs_op1;
    logic [WIDTH-1:0] w_abs_op2;
    logic             w_div_zero;
    logic             w_overflow;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_trial;
    logic             w_trial_neg;

    assign w_op1_neg  = bus.i_is_signed & bus.i_operator_1[WIDTH-1];
    assign w_op2_neg  = bus.i_is_signed & bus.i_operator_2[WIDTH-1];
    // abs(MIN_NEG) wraps to MIN_NEG, which is the correct unsigned 2^31.
    assign w_abs_op1  = w_op1_neg ? (~bus.i_operator_1 + 1'b1) : bus.i_operator_1;
    assign w_abs_op2  = w_op2_neg ? (~bus.i_operator_2 + 1'b1) : bus.i_operator_2;
    assign w_div_zero = (bus.i_operator_2 == '0);
    assign w_overflow = bus.i_is_signed & (bus.i_operator_1 == MIN_NEG) & (&bus.i_operator_2);

    // 33-bit shifted remainder minus divisor; the extra top bit is the borrow,
    // so unsigned divisors up to 2^32-1 compare correctly.
    assign w_shift     = {r_partial_rem, r_dividend[WIDTH-1]};
    assign w_trial     = {1'b0, w_shift} - {2'b00, r_abs_divisor};
    assign w_trial_neg = w_trial[WIDTH+1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state         <= S_IDLE;
            r_counter       <= '0;
            r_dividend      <= '0;
            r_partial_rem   <= '0;
            r_abs_divisor   <= '0;
            r_orig_dividend <= '0;
            r_neg_q         <= 1'b0;
            r_neg_r         <= 1'b0;
            r_div_zero      <= 1'b0;
            r_overflow      <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_quotient      <= '0;
            r_remainder     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        r_dividend      <= w_abs_op1;
                        r_abs_divisor   <= w_abs_op2;
                        r_orig_dividend <= bus.i_operator_1;
                        r_neg_q         <= w_op1_neg ^ w_op2_neg;
                        r_neg_r         <= w_op1_neg;
                        r_div_zero      <= w_div_zero;
                        r_overflow      <= w_overflow;
                        r_partial_rem   <= '0;
                        r_counter       <= '0;
                        r_busy          <= 1'b1;
`ifdef DIV_FAST_SPECIAL_EN
                        if (w_div_zero || w_overflow)
                            r_state <= S_FINISH;
                        else
                            r_state <= S_CALC;
`else
                        r_state <= S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    if (w_trial_neg) begin
                        r_partial_rem <= w_shift[WIDTH-1:0];
                        r_dividend    <= {r_dividend[WIDTH-2:0], 1'b0};
                    end else begin
                        r_partial_rem <= w_trial[WIDTH-1:0];
                        r_dividend    <= {r_dividend[WIDTH-2:0], 1'b1};
                    end
                    r_counter <= r_counter + CW'(1);
                    if (r_counter == CW'(ITER - 1))
                        r_state <= S_FINISH;
                end
                S_FINISH: begin
                    // Special cases bypass sign fix-up so it cannot corrupt them.
                    if (r_div_zero) begin
                        r_quotient  <= '1;
                        r_remainder <= r_orig_dividend;
                    end else if (r_overflow) begin
                        r_quotient  <= MIN_NEG;
                        r_remainder <= '0;
                    end else begin
                        r_quotient  <= r_neg_q ? (~r_dividend + 1'b1) : r_dividend;
                        r_remainder <= r_neg_r ? (~r_partial_rem + 1'b1) : r_partial_rem;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_busy      = r_busy;
    assign bus.o_done      = r_done;
    assign bus.o_quotient  = r_quotient;
    assign bus.o_remainder = r_remainder;
endmodule

// File: tb/tb_thirty_two_bit_divider.sv
// tb/tb_thirty_two_bit_divider.sv - directed self-checking bench for thirty_two_bit_divider
module tb_thirty_two_bit_divider;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

`ifdef DIV_FAST_SPECIAL_EN
    localparam int SPECIAL_LAT = 1;
`else
    localparam int SPECIAL_LAT = 33;
`endif

    thirty_two_bit_divider_if #(.WIDTH(32)) bus ();

    thirty_two_bit_divider #(.WIDTH(32), .ITER(32)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation; lat = cycles from accept edge to the edge raising done,
    // bcyc = number of post-edge samples with busy high.
    task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int bcyc);
        @(negedge clk);
        bus.i_start      = 1'b1;
        bus.i_is_signed  = s;
        bus.i_operator_1 = a;
        bus.i_operator_2 = b;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        lat  = 0;
        bcyc = 0;
        while (bus.o_done !== 1'b1 && lat < 100) begin
            if (bus.o_busy === 1'b1) bcyc++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_start = 1'b0;
        bus.i_is_signed = 1'b0;
        bus.i_operator_1 = '0;
        bus.i_operator_2 = '0;
        #1;
        n_cmp++;
        if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 ||
            bus.o_quotient !== 32'h0 || bus.o_remainder !== 32'h0) begin
            $display("FAIL reset_state: busy=%b done=%b q=%h r=%h required 0 0 0 0",
                     bus.o_busy, bus.o_done, bus.o_quotient, bus.o_remainder);
            n_err++;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_unsigned();
        int lat, bcyc;
        do_op(1'b0, 32'd100, 32'd7, lat, bcyc);
        n_cmp++;
        if (lat !== 33) begin $display("FAIL unsigned_latency: got %0d required 33", lat); n_err++; end
        n_cmp++;
        if (bcyc !== 33) begin $display("FAIL unsigned_busy_cycles: got %0d required 33", bcyc); n_err++; end
        n_cmp++;
        if (bus.o_quotient !== 32'd14) begin $display("FAIL unsigned_quotient: got %h required %h", bus.o_quotient, 32'd14); n_err++; end
        n_cmp++;
        if (bus.o_remainder !== 32'd2) begin $display("FAIL unsigned_remainder: got %h required %h", bus.o_remainder, 32'd2); n_err++; end
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) begin
            $display("FAIL done_pulse_width: done=%b busy=%b required 0 0", bus.o_done, bus.o_busy); n_err++;
        end
        n_cmp++;
        if (bus.o_quotient !== 32'd14) begin $display("FAIL quotient_hold: got %h required %h", bus.o_quotient, 32'd14); n_err++; end
    endtask

    task automatic test_signed();
        int lat, bcyc;
        do_op(1'b1, 32'hFFFFFFF9, 32'd2, lat, bcyc);
        n_cmp++;
        if (lat !== 33) begin $display("FAIL signed_neg_pos_latency: got %0d required 33", lat); n_err++; end
        n_cmp++;
        if (bus.o_quotient !== 32'hFFFFFFFD || bus.o_remainder !== 32'hFFFFFFFF) begin
            $display("FAIL signed_neg_pos: q=%h r=%h required FFFFFFFD FFFFFFFF", bus.o_quotient, bus.o_remainder); n_err++;
        end
        do_op(1'b1, 32'd7, 32'hFFFFFFFE, lat, bcyc);
        n_cmp++;
        if (bus.o_quotient !== 32'hFFFFFFFD || bus.o_remainder !== 32'h00000001) begin
            $display("FAIL signed_pos_neg: q=%h r=%h required FFFFFFFD 00000001", bus.o_quotient, bus.o_remainder); n_err++;
        end
        do_op(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, lat, bcyc);
        n_cmp++;
        if (bus.o_quotient !== 32'h00000003 || bus.o_remainder !== 32'hFFFFFFFF) begin
            $display("FAIL signed_neg_neg: q=%h r=%h required 00000003 FFFFFFFF", bus.o_quotient, bus.o_remainder); n_err++;
        end
        do_op(1'b0, 32'hFFFFFFFF, 32'h00000010, lat, bcyc);
        n_cmp++;
        if (bus.o_quotient !== 32'h0FFFFFFF || bus.o_remainder !== 32'h0000000F) begin
            $display("FAIL unsigned_large: q=%h r=%h required 0FFFFFFF 0000000F", bus.o_quotient, bus.o_remainder); n_err++;
        end
    endtask

    task automatic test_div_zero();
        int lat, bcyc;
        for (int m = 0; m < 2; m++) begin
            do_op(m[0], 32'h12345678, 32'h0, lat, bcyc);
            n_cmp++;
            if (lat !== SPECIAL_LAT) begin
                $display("FAIL div_zero_latency(signed=%0d): got %0d required %0d", m, lat, SPECIAL_LAT); n_err++;
            end
            n_cmp++;
            if (bus.o_quotient !== 32'hFFFFFFFF || bus.o_remainder !== 32'h12345678) begin
                $display("FAIL div_zero(signed=%0d): q=%h r=%h required FFFFFFFF 12345678",
                         m, bus.o_quotient, bus.o_remainder); n_err++;
            end
        end
        do_op(1'b1, 32'hFFFFFFF9, 32'h0, lat, bcyc);
        n_cmp++;
        if (bus.o_quotient !== 32'hFFFFFFFF || bus.o_remainder !== 32'hFFFFFFF9) begin
            $display("FAIL div_zero_neg_dividend: q=%h r=%h required FFFFFFFF FFFFFFF9", bus.o_quotient, bus.o_remainder); n_err++;
        end
    endtask

    task automatic test_overflow();
        int lat, bcyc;
        do_op(1'b1, 32'h80000000, 32'hFFFFFFFF, lat, bcyc);
        n_cmp++;
        if (lat !== SPECIAL_LAT) begin $display("FAIL overflow_latency: got %0d required %0d", lat, SPECIAL_LAT); n_err++; end
        n_cmp++;
        if (bcyc !== SPECIAL_LAT) begin $display("FAIL overflow_busy_cycles: got %0d required %0d", bcyc, SPECIAL_LAT); n_err++; end
        n_cmp++;
        if (bus.o_quotient !== 32'h80000000 || bus.o_remainder !== 32'h0) begin
            $display("FAIL overflow_signed: q=%h r=%h required 80000000 00000000", bus.o_quotient, bus.o_remainder); n_err++;
        end
        do_op(1'b0, 32'h80000000, 32'hFFFFFFFF, lat, bcyc);
        n_cmp++;
        if (lat !== 33) begin $display("FAIL overflow_unsigned_latency: got %0d required 33", lat); n_err++; end
        n_cmp++;
        if (bus.o_quotient !== 32'h0 || bus.o_remainder !== 32'h80000000) begin
            $display("FAIL overflow_unsigned: q=%h r=%h required 00000000 80000000", bus.o_quotient, bus.o_remainder); n_err++;
        end
        do_op(1'b1, 32'h80000000, 32'h00000002, lat, bcyc);
        n_cmp++;
        if (bus.o_quotient !== 32'hC0000000 || bus.o_remainder !== 32'h0) begin
            $display("FAIL min_neg_div2: q=%h r=%h required C0000000 00000000", bus.o_quotient, bus.o_remainder); n_err++;
        end
    endtask

    task automatic test_ignore_start();
        int dones, first;
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_is_signed = 1'b0;
        bus.i_operator_1 = 32'd100; bus.i_operator_2 = 32'd7;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        dones = 0;
        first = -1;
        for (int i = 1; i <= 45; i++) begin
            // Drive intruding requests so they are sampled at edges k+5 and k+20.
            if (i == 5 || i == 20) begin
                bus.i_start = 1'b1; bus.i_is_signed = 1'b1;
                bus.i_operator_1 = 32'h55555555; bus.i_operator_2 = 32'd3;
            end
            @(posedge clk);
            #1;
            bus.i_start = 1'b0;
            if (bus.o_done === 1'b1) begin
                dones++;
                if (first < 0) first = i;
            end
        end
        n_cmp++;
        if (dones !== 1) begin $display("FAIL ignore_start_done_count: got %0d required 1", dones); n_err++; end
        n_cmp++;
        if (first !== 33) begin $display("FAIL ignore_start_latency: got %0d required 33", first); n_err++; end
        n_cmp++;
        if (bus.o_quotient !== 32'd14 || bus.o_remainder !== 32'd2) begin
            $display("FAIL ignore_start_result: q=%h r=%h required 0000000E 00000002", bus.o_quotient, bus.o_remainder); n_err++;
        end
    endtask

    task automatic test_back_to_back();
        int lat, bcyc, gap;
        do_op(1'b0, 32'd1000, 32'd10, lat, bcyc);
        n_cmp++;
        if (bus.o_quotient !== 32'd100 || bus.o_remainder !== 32'd0) begin
            $display("FAIL b2b_first: q=%h r=%h required 00000064 00000000", bus.o_quotient, bus.o_remainder); n_err++;
        end
        // Still in the done cycle: request the next operation.
        bus.i_start = 1'b1; bus.i_is_signed = 1'b1;
        bus.i_operator_1 = 32'hFFFFFF9C; bus.i_operator_2 = 32'd9;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        gap = 1;
        while (bus.o_done !== 1'b1 && gap < 100) begin
            @(posedge clk);
            #1;
            gap++;
        end
        n_cmp++;
        if (gap !== 34) begin $display("FAIL b2b_gap: got %0d required 34", gap); n_err++; end
        n_cmp++;
        if (bus.o_quotient !== 32'hFFFFFFF5 || bus.o_remainder !== 32'hFFFFFFFF) begin
            $display("FAIL b2b_second: q=%h r=%h required FFFFFFF5 FFFFFFFF", bus.o_quotient, bus.o_remainder); n_err++;
        end
    endtask

    task automatic test_reset_midop();
        int dones;
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_is_signed = 1'b0;
        bus.i_operator_1 = 32'd500; bus.i_operator_2 = 32'd3;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        repeat (9) @(posedge clk);
        @(posedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 ||
            bus.o_quotient !== 32'h0 || bus.o_remainder !== 32'h0) begin
            $display("FAIL reset_midop: busy=%b done=%b q=%h r=%h required 0 0 0 0",
                     bus.o_busy, bus.o_done, bus.o_quotient, bus.o_remainder); n_err++;
        end
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (bus.o_done === 1'b1 || bus.o_busy === 1'b1) dones++;
        end
        n_cmp++;
        if (dones !== 0) begin $display("FAIL reset_no_done: activity cycles %0d required 0", dones); n_err++; end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_ignore_start();
        test_back_to_back();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
